// File: rtl/clock_set_ctrl.sv
// Mode/sequencing controller for the digital clock: cascaded count enables in RUN,
// single-cycle Load/D strobes to step the hours or minutes field in the SET modes.
`timescale 1ns/100ps
module clock_set_ctrl #(
  parameter logic [7:0] HOUR_MAX    = 8'h23,
  parameter logic [7:0] MIN_MAX     = 8'h59,
  parameter int         BLINK_TICKS = 1
) (
  input  logic       CP,
  input  logic       nCLR,
  input  logic       tick,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic [7:0] sec_q,
  input  logic [7:0] min_q,
  input  logic [7:0] hour_q,
  output logic       sec_en,
  output logic       min_en,
  output logic       hour_en,
  output logic       sec_load,
  output logic       min_load,
  output logic       hour_load,
  output logic [7:0] load_d,
  output logic [1:0] mode,
  output logic       blink
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } state_t;

  localparam logic [3:0] BLINK_LAST = 4'(BLINK_TICKS - 1);

  state_t     state;
  state_t     next_state;
  logic [3:0] blink_cnt;
  logic       load_pending;
  logic       run_tick;

  // BCD +1 with wrap at max; anything malformed or out of range restarts at 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v[3:0] > 4'd9 || v[7:4] > 4'd9 || v >= max)
      return 8'h00;
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return v + 8'd1;
  endfunction

  assign load_pending = sec_load | min_load | hour_load;
  assign mode         = state;

  always_comb begin
    next_state = RUN;
    case (state)
      RUN:     next_state = SET_HR;
      SET_HR:  next_state = SET_MIN;
      default: next_state = RUN;
    endcase
  end

  // Enables are gated by nCLR so the counters stay frozen while reset is held.
  always_comb begin
    run_tick = nCLR & (state == RUN) & tick;
    sec_en   = run_tick;
    min_en   = run_tick & (sec_q == MIN_MAX);
    hour_en  = min_en & (min_q == MIN_MAX);
  end

  always_ff @(posedge CP or negedge nCLR) begin
    if (!nCLR) begin
      state     <= RUN;
      sec_load  <= 1'b0;
      min_load  <= 1'b0;
      hour_load <= 1'b0;
      load_d    <= 8'h00;
      blink     <= 1'b0;
      blink_cnt <= 4'd0;
    end else begin
      sec_load  <= 1'b0;
      min_load  <= 1'b0;
      hour_load <= 1'b0;
      if (mode_btn) begin
        // Mode change outranks a same-cycle increment; leaving SET_MIN zeroes seconds.
        state     <= next_state;
        blink     <= 1'b0;
        blink_cnt <= 4'd0;
        if (state == SET_MIN) begin
          sec_load <= 1'b1;
          load_d   <= 8'h00;
        end
      end else begin
        if (inc_btn && !load_pending) begin
          case (state)
            SET_HR: begin
              hour_load <= 1'b1;
              load_d    <= bcd_inc(hour_q, HOUR_MAX);
            end
            SET_MIN: begin
              min_load <= 1'b1;
              load_d   <= bcd_inc(min_q, MIN_MAX);
            end
            default: ;
          endcase
        end
        if (state != RUN && tick) begin
          if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= 4'd0;
            blink     <= ~blink;
          end else begin
            blink_cnt <= blink_cnt + 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- Mode/sequencing controller for the digital-clock datapath, i.e. the BCD seconds/minutes `counter60` pair and the hours `counter24`.
- In RUN it produces the cascaded count enables from a 1 Hz tick.
- In SET modes it freezes counting and drives each counter's Load/D port to step the selected field.
- Sits between the debounced buttons, the tick prescaler and the three counters.

Parameters:
- HOUR_MAX, 8'h23, BCD terminal value of the hours field.
- MIN_MAX, 8'h59, BCD terminal value of the minutes and seconds fields.
- BLINK_TICKS, 1, number of ticks between blink toggles in SET modes (1..15).

Ports:
- CP  in  1  system clock, rising edge.
- nCLR  in  1  asynchronous active-low reset.
- tick  in  1  one-CP-wide 1 Hz enable pulse.
- mode_btn  in  1  one-cycle debounced pulse: advance mode.
- inc_btn  in  1  one-cycle debounced pulse: increment selected field.
- sec_q  in  8  BCD seconds from the counter.
- min_q  in  8  BCD minutes from the counter.
- hour_q  in  8  BCD hours from the counter.
- sec_en  out  1  count enable, seconds counter.
- min_en  out  1  count enable, minutes counter.
- hour_en  out  1  count enable, hours counter.
- sec_load  out  1  synchronous load strobe, seconds counter.
- min_load  out  1  synchronous load strobe, minutes counter.
- hour_load  out  1  synchronous load strobe, hours counter.
- load_d  out  8  BCD value shared by all counter D inputs.
- mode  out  2  current state: 0 RUN, 1 SET_HR, 2 SET_MIN.
- blink  out  1  display blink for the selected field; 0 in RUN.

Behaviour:
- Reset (nCLR=0, async): state RUN; all *_load=0; load_d=8'h00; blink=0; blink counter=0; load_pending=0. The *_en outputs are combinational and are 0 while in reset.
- FSM, advanced only by mode_btn:
  - RUN -> SET_HR -> SET_MIN -> RUN.
  - On the SET_MIN -> RUN transition: sec_load=1 and load_d=8'h00 for one cycle, so seconds restart at 00.
- RUN enables (combinational, same cycle as tick):
  - sec_en = tick.
  - min_en = tick & (sec_q==MIN_MAX).
  - hour_en = min_en & (min_q==MIN_MAX).
- SET_HR / SET_MIN: all *_en=0, so time is frozen and tick only drives blink.
- Increment:
  - inc_btn sampled in a SET state with load_pending=0 is accepted.
  - Next cycle the selected field's *_load=1 (registered, exactly one cycle) and load_d = BCD(field+1).
  - Counter updates on the following edge, so the field changes 2 CP edges after inc_btn.
- Back-to-back protection:
  - load_pending=1 for the cycle in which a load strobe is high.
  - inc_btn arriving in that cycle is dropped, not queued.
- BCD increment rules:
  - Low nibble 9 -> 0 with carry into the high nibble.
  - Field equal to its MAX wraps to 8'h00 (hours 23->00, minutes 59->00).
  - Any invalid BCD input (nibble > 9, or value > MAX) yields 8'h00.
- Priority: mode_btn and inc_btn in the same cycle -> the mode change wins and inc is dropped.
- inc_btn in RUN is ignored.
- At most one *_load is high in any cycle. The exit-to-RUN sec_load never coincides with an increment load, because a pending increment completes before the state exit takes effect.
- Blink:
  - In SET states, blink toggles every BLINK_TICKS ticks.
  - Blink counter and blink are cleared to 0 on every state change.
- Reset mid-load: the strobe is cleared immediately and no partial load is issued after release.
- load_d holds its last value when no load is active.

Test Plan:
- Reset with nCLR pulse 0.5 ns low, then release -> mode=0, all loads 0, load_d=8'h00, blink=0; with tick=1 and sec_q=8'h12 -> sec_en=1, min_en=0.
- Cascade: RUN, sec_q=8'h59, min_q=8'h59, hour_q=8'h23, tick=1 -> sec_en=min_en=hour_en=1; same inputs with tick=0 -> all enables 0.
- Hour set: mode_btn once (mode=1), hour_q=8'h09, inc_btn -> next cycle hour_load=1, load_d=8'h10; repeat with hour_q=8'h23 -> load_d=8'h00; tick=1 meanwhile -> hour_en=0.
- Minute set and exit: mode_btn twice, min_q=8'h59, inc_btn -> min_load=1, load_d=8'h00; mode_btn -> mode=0 and one cycle of sec_load=1 with load_d=8'h00.
- Collisions: inc_btn on consecutive cycles -> only one load strobe; mode_btn with inc_btn in SET_HR -> mode=2, no load; nCLR low during a load cycle -> strobe drops at once, mode=0.
- Invalid BCD: SET_MIN with min_q=8'h5A or 8'h60, inc_btn -> load_d=8'h00; blink toggles on every tick with BLINK_TICKS=1 and reads 0 right after each mode change.
